// File: rtl/ro_entropy_packer.sv
`default_nettype none
// ============================================================================
// Module   : ro_entropy_packer
// Brief    : Synchronises a bank of free-running ring oscillators, XOR-combines
//            them into one raw bit per enabled cycle, runs a repetition-count
//            health test, optionally debiases (von Neumann) and packs the bits
//            into WORD_WIDTH words on a valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module ro_entropy_packer #(
  parameter int NUM_RO      = 8,   // ring-oscillator inputs (>=1)
  parameter int SYNC_STAGES = 2,   // flops per RO synchroniser (>=2)
  parameter int WORD_WIDTH  = 32,  // output word width (>=2)
  parameter int DEBIAS      = 1,   // 1 = von Neumann corrector in path
  parameter int REP_LIMIT   = 34   // identical raw bits that trip health test
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_RO-1:0]     ro_in,
  output logic [WORD_WIDTH-1:0] word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  health_fail,
  input  logic                  health_clear,
  output logic [15:0]           drop_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int RUN_W = $clog2(REP_LIMIT + 1);
  localparam int CNT_W = $clog2(WORD_WIDTH);

  localparam logic [RUN_W-1:0] c_RUN_MAX  = RUN_W'(REP_LIMIT);
  localparam logic [RUN_W-1:0] c_RUN_ONE  = RUN_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WORD_WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      c_DROP_MAX = 16'hFFFF;

  // --------------------------------------------------------------------------
  // Synchroniser and raw XOR stage
  // --------------------------------------------------------------------------
  // Index 0 is the newest sample, SYNC_STAGES-1 the fully synchronised one.
  logic [SYNC_STAGES-1:0][NUM_RO-1:0] sync_q;
  logic                               raw_bit_q;
  logic                               raw_valid_q;

  // Shift every RO line through its synchroniser chain on every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
    end
  end

  // Combine the synchronised bank into one raw bit when sampling is enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw_bit_q   <= 1'b0;
      raw_valid_q <= 1'b0;
    end else begin
      raw_valid_q <= enable;
      if (enable) begin
        raw_bit_q <= ^sync_q[SYNC_STAGES-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Repetition-count health test (on the raw stream, before debias)
  // --------------------------------------------------------------------------
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;
  logic             fail_q, fail_d;

  // Track the current run length; a clear discards the bit of its cycle.
  always_comb begin
    run_d  = run_q;
    prev_d = prev_q;
    fail_d = fail_q;
    if (health_clear) begin
      run_d  = '0;
      fail_d = 1'b0;
    end else if (raw_valid_q) begin
      prev_d = raw_bit_q;
      // run_q == 0 means no previous bit since reset or clear
      if ((run_q != '0) && (raw_bit_q == prev_q)) begin
        if (run_q != c_RUN_MAX) begin
          run_d = run_q + c_RUN_ONE;
        end
      end else begin
        run_d = c_RUN_ONE;
      end
      if (run_d == c_RUN_MAX) begin
        fail_d = 1'b1;
      end
    end
  end

  // Health-test state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q  <= '0;
      prev_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      prev_q <= prev_d;
      fail_q <= fail_d;
    end
  end

  // A raw bit reaches the corrector/packer only if it is valid, not discarded
  // by a clear and the source is currently healthy.
  logic w_bit_ok;
  assign w_bit_ok = raw_valid_q & ~health_clear & ~fail_q;

  // --------------------------------------------------------------------------
  // Bias corrector
  // --------------------------------------------------------------------------
  logic w_emit_valid;
  logic w_emit_bit;

  generate
    if (DEBIAS != 0) begin : g_debias
      localparam logic [0:0] c_PAIR_A = 1'b0;
      localparam logic [0:0] c_PAIR_B = 1'b1;

      logic [0:0] state_q, state_d;
      logic       a_q, a_d;

      // Pair-tracking state and the held first bit of the pair.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_q <= c_PAIR_A;
          a_q     <= 1'b0;
        end else begin
          state_q <= state_d;
          a_q     <= a_d;
        end
      end

      // Alternate between first and second bit of a pair; unhealthy forces A.
      always_comb begin
        state_d = state_q;
        a_d     = a_q;
        if (fail_q) begin
          state_d = c_PAIR_A;
        end else if (w_bit_ok) begin
          case (state_q)
            c_PAIR_A: begin
              state_d = c_PAIR_B;
              a_d     = raw_bit_q;
            end
            default: begin
              state_d = c_PAIR_A;
            end
          endcase
        end
      end

      // Emit the first bit of an unequal pair; equal pairs are discarded.
      always_comb begin
        w_emit_valid = 1'b0;
        w_emit_bit   = a_q;
        if (w_bit_ok && (state_q == c_PAIR_B) && (a_q != raw_bit_q)) begin
          w_emit_valid = 1'b1;
        end
      end
    end else begin : g_raw
      assign w_emit_valid = w_bit_ok;
      assign w_emit_bit   = raw_bit_q;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Packer, one-deep pending buffer and output register
  // --------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [WORD_WIDTH-1:0] pend_word_q, pend_word_d;
  logic                  pend_q, pend_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic                  valid_q, valid_d;
  logic [15:0]           drop_q, drop_d;

  logic [WORD_WIDTH-1:0] w_full_word;
  logic                  w_complete;

  // First bit of a word lands at the MSB once WORD_WIDTH bits have shifted in.
  assign w_full_word = {shift_q[WORD_WIDTH-2:0], w_emit_bit};
  assign w_complete  = w_emit_valid && (count_q == c_CNT_LAST);

  // Route completed words to the output, the pending slot, or drop them.
  always_comb begin
    shift_d     = shift_q;
    count_d     = count_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    word_d      = word_q;
    drop_d      = drop_q;
    // A transfer this cycle frees the output register
    valid_d     = valid_q & ~word_ready;

    // The pending word takes a freed output before any same-edge completion
    if (pend_q && !valid_d) begin
      word_d  = pend_word_q;
      valid_d = 1'b1;
      pend_d  = 1'b0;
    end

    if (w_complete) begin
      if (!valid_d) begin
        word_d  = w_full_word;
        valid_d = 1'b1;
        count_d = '0;
      end else if (!pend_d) begin
        pend_word_d = w_full_word;
        pend_d      = 1'b1;
        count_d     = '0;
      end else if (drop_q != c_DROP_MAX) begin
        // Both slots full: the completing bit is lost, partial word kept
        drop_d = drop_q + 16'd1;
      end
    end else if (w_emit_valid) begin
      shift_d = w_full_word;
      count_d = count_q + c_CNT_ONE;
    end

    // An unhealthy source restarts word assembly from scratch
    if (fail_q) begin
      count_d = '0;
    end
  end

  // Packer, pending and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q     <= '0;
      count_q     <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      drop_q      <= '0;
    end else begin
      shift_q     <= shift_d;
      count_q     <= count_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      drop_q      <= drop_d;
    end
  end

  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign health_fail = fail_q;
  assign drop_count  = drop_q;

endmodule
`default_nettype wire
